sevenseg_bcd_counter: RTL and testbench

Four-digit BCD up-counter with multiplexed seven-segment display drive. Sits directly downstream of the counter clock-enable divider: it consumes the divider's single-cycle enable pulse as its count tick and drives the board's common-anode 4-digit display. Counting, scan multiplexing and segment decode are all in this block; outputs connect straight to pins.

---
 rtl/sevenseg_bcd_counter.sv | 124 ++++++++++++
 tb/tb_sevenseg_bcd_counter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sevenseg_bcd_counter.sv
// Four-digit BCD up-counter with a multiplexed, active-low common-anode seven-segment drive.
// Define SEVENSEG_LZB_EN to blank leading zeros on digits 1..3.
module sevenseg_bcd_counter #(
    parameter int SCAN_DIV = 10000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CE,
    input  logic       EN,
    input  logic       CLR,
    output logic [6:0] SEG,
    output logic       DP,
    output logic [3:0] AN,
    output logic       CARRY
);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    logic [3:0][3:0]    count_reg;
    logic [3:0][3:0]    count_next;
    logic [SCAN_W-1:0]  scan_reg;
    logic [1:0]         index_reg;
    logic [6:0]         seg_reg;
    logic [6:0]         seg_next;
    logic [3:0]         an_reg;
    logic [3:0]         an_next;
    logic               carry_reg;
    logic               tick;
    logic [4:0]         inc;
    logic [3:0]         blank;
    logic [3:0]         cur_digit;

    assign tick   = CE & EN & ~CLR;
    assign inc[0] = tick;

    // A digit advances when every lower digit sits at 9; inc[4] flags the 9999 -> 0000 wrap.
    genvar gi;
    generate
        for (gi = 1; gi <= 4; gi++) begin : g_inc
            assign inc[gi] = tick && (count_reg[gi-1:0] == {gi{4'h9}});
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        if (CLR) begin
            count_next = '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (inc[i]) begin
                    count_next[i] = (count_reg[i] == 4'd9) ? 4'd0 : count_reg[i] + 4'd1;
                end
            end
        end
    end

    assign blank[0] = 1'b0;
`ifdef SEVENSEG_LZB_EN
    generate
        for (gi = 1; gi < 4; gi++) begin : g_blank
            assign blank[gi] = (count_reg[3:gi] == '0);
        end
    endgenerate
`else
    assign blank[3:1] = 3'b000;
`endif

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Display follows the live count, so a change shows up one edge later without waiting for a slot.
    always_comb begin
        cur_digit = count_reg[index_reg];
        seg_next  = seg_decode(cur_digit);
        an_next   = ~(4'b0001 << index_reg);
        if (blank[index_reg]) begin
            seg_next = 7'h7F;
            an_next  = 4'hF;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_reg <= '0;
            carry_reg <= 1'b0;
            scan_reg  <= '0;
            index_reg <= 2'd0;
            seg_reg   <= 7'h7F;
            an_reg    <= 4'hF;
        end else begin
            count_reg <= count_next;
            carry_reg <= inc[4];
            seg_reg   <= seg_next;
            an_reg    <= an_next;
            if (scan_reg == SCAN_LAST) begin
                scan_reg  <= '0;
                index_reg <= index_reg + 2'd1;
            end else begin
                scan_reg  <= scan_reg + 1'b1;
            end
        end
    end

    assign SEG   = seg_reg;
    assign AN    = an_reg;
    assign DP    = 1'b1;
    assign CARRY = carry_reg;

endmodule

// File: tb/tb_sevenseg_bcd_counter.sv
// Directed bench for sevenseg_bcd_counter: table of count vectors plus reset, scan and blanking sequences.
module tb_sevenseg_bcd_counter;
    localparam int SD = 4;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b0;
    logic       CE    = 1'b0;
    logic       EN    = 1'b0;
    logic       CLR   = 1'b0;
    logic [6:0] SEG;
    logic       DP;
    logic [3:0] AN;
    logic       CARRY;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    sevenseg_bcd_counter #(.SCAN_DIV(SD)) dut (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .EN(EN), .CLR(CLR),
        .SEG(SEG), .DP(DP), .AN(AN), .CARRY(CARRY)
    );

    typedef struct {
        int          pulses;
        logic        en;
        logic        clr;
        logic [15:0] exp_count;
        int          exp_carries;
    } vec_t;

    vec_t       vecs [13];
    logic [6:0] seg_tab [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Watch one full refresh and rebuild the count from the anode/segment pairs.
    task automatic capture(output logic [15:0] val);
        logic [3:0] d;
        int         idx;
        bit         bad;
        val = '0;
        bad = 1'b0;
        repeat (4 * SD) begin
            @(negedge CLK);
            if (AN == 4'hF) begin
`ifndef SEVENSEG_LZB_EN
                bad = 1'b1;
`endif
            end else begin
                idx = -1;
                for (int i = 0; i < 4; i++)
                    if (AN == 4'(~(4'b0001 << i))) idx = i;
                if (idx < 0) begin
                    bad = 1'b1;
                end else begin
                    d = 4'hF;
                    for (int k = 0; k < 10; k++)
                        if (SEG == seg_tab[k]) d = 4'(k);
                    if (d == 4'hF) bad = 1'b1;
                    val[idx*4 +: 4] = d;
                end
            end
        end
        if (bad) val = 16'hBAD0;
    endtask

    task automatic apply(input vec_t v, input int n);
        int          hits;
        logic [15:0] got;
        hits = 0;
        for (int p = 0; p < v.pulses; p++) begin
            CE = 1'b1; EN = v.en; CLR = v.clr;
            @(negedge CLK);
            if (CARRY) hits++;
        end
        CE = 1'b0; EN = 1'b1; CLR = 1'b0;
        @(negedge CLK);
        check($sformatf("vec%0d carry_pulses", n), hits, v.exp_carries);
        check($sformatf("vec%0d carry_low_after", n), {31'd0, CARRY}, 32'd0);
        capture(got);
        check($sformatf("vec%0d count", n), {16'd0, got}, {16'd0, v.exp_count});
    endtask

    initial begin
        logic [3:0]  exp_an;
        logic [15:0] got;
        int          dark;
        vec_t        v42;

        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;

        vecs[0]  = '{10,   1'b1, 1'b0, 16'h0010, 0};
        vecs[1]  = '{5,    1'b0, 1'b0, 16'h0010, 0};
        vecs[2]  = '{989,  1'b1, 1'b0, 16'h0999, 0};
        vecs[3]  = '{1,    1'b1, 1'b0, 16'h1000, 0};
        vecs[4]  = '{1,    1'b1, 1'b1, 16'h0000, 0};
        vecs[5]  = '{9999, 1'b1, 1'b0, 16'h9999, 0};
        vecs[6]  = '{1,    1'b1, 1'b0, 16'h0000, 1};
        vecs[7]  = '{1,    1'b1, 1'b0, 16'h0001, 0};
        vecs[8]  = '{9998, 1'b1, 1'b0, 16'h9999, 0};
        vecs[9]  = '{1,    1'b1, 1'b1, 16'h0000, 0};
        vecs[10] = '{2468, 1'b1, 1'b0, 16'h2468, 0};
        vecs[11] = '{1,    1'b0, 1'b1, 16'h0000, 0};
        vecs[12] = '{537,  1'b1, 1'b0, 16'h0537, 0};

        // Reset held for three cycles.
        repeat (3) @(negedge CLK);
        check("reset_seg",   {25'd0, SEG},  32'h7F);
        check("reset_an",    {28'd0, AN},   32'hF);
        check("reset_dp",    {31'd0, DP},   32'd1);
        check("reset_carry", {31'd0, CARRY}, 32'd0);

        // Release and follow the scan; slot k/4 is shown after edge k+1.
        RST_N = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            exp_an = 4'(~(4'b0001 << ((k % 16) / 4)));
`ifdef SEVENSEG_LZB_EN
            if (((k % 16) / 4) != 0) exp_an = 4'hF;
`endif
            check($sformatf("scan_an_k%0d", k), {28'd0, AN}, {28'd0, exp_an});
            if (k == 0) check("first_seg", {25'd0, SEG}, 32'b1000000);
        end

        EN = 1'b1;
        for (int n = 0; n < 13; n++) apply(vecs[n], n);

        // Asynchronous reset between edges while showing 0537.
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("async_seg",   {25'd0, SEG},  32'h7F);
        check("async_an",    {28'd0, AN},   32'hF);
        check("async_carry", {31'd0, CARRY}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        capture(got);
        check("async_count_cleared", {16'd0, got}, 32'h0000);

        // 0042: with blanking enabled, slots 2 and 3 stay dark.
        v42 = '{42, 1'b1, 1'b0, 16'h0042, 0};
        apply(v42, 13);
        dark = 0;
        repeat (4 * SD) begin
            @(negedge CLK);
            if (AN == 4'hF) dark++;
        end
`ifdef SEVENSEG_LZB_EN
        check("lzb_dark_cycles", dark, 2 * SD);
`else
        check("lzb_dark_cycles", dark, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
